rvvi_ack_depacketizer: RTL
==========================

RVVI_ACK_DEPACKETIZER -- requirements
Module: rvvi_ack_depacketizer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the saturating statistics counters.
REQ-002 SHALL have parameter MIN_WORDS, default 6: minimum number of 32-bit words in an accepted frame (4 header + 2 frame-count).
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 RxAxiTdata  input  32  received frame word; byte 0 of the word is the earliest byte on the wire.
REQ-006 RxAxiTvalid  input  1  RxAxiTdata is valid.
REQ-007 RxAxiTlast  input  1  the current word is the last word of the frame.
REQ-008 RxAxiTready  output  1  the block accepts a word when this is high.
REQ-009 LocalMac  input  48  MAC address this block accepts as destination.
REQ-010 EthType, AckType  input  16 each  expected type fields.
REQ-011 TxFrameCount  input  64  count of frames the packetizer has sent.
REQ-012 MaxInFlight  input  32  unacknowledged frame limit.
REQ-013 AckValid  output  1  one-cycle pulse: AckFrameCount updated.
REQ-014 AckFrameCount  output  64  last accepted acknowledged frame count.
REQ-015 Throttle  output  1  high while the number of outstanding frames exceeds MaxInFlight.
REQ-016 DropCount, ShortCount, StaleCount  output  CNT_WIDTH each  statistics counters.

Function
REQ-017 Handshake: a word transfers on a cycle with RxAxiTvalid & RxAxiTready; RxAxiTready SHALL be 1 in every state except RST.
REQ-018 Frame layout by word index w, counted from 0 and incremented per transfer: w0=DstMac[31:0]; w1={SrcMac[15:0],DstMac[47:32]}; w2=SrcMac[47:16]; w3={AckType,EthType}; w4=Count[31:0]; w5=Count[63:32]; words w6 and later are ignored.
REQ-019 States: RST, HDR, CNT, DRAIN, COMMIT.
REQ-020 RST -> HDR unconditionally one cycle after reset deasserts.
REQ-021 HDR receives w0..w3 and holds a match flag; match = (DstMac==LocalMac)&(EthType field==EthType)&(AckType field==AckType).
REQ-022 HDR: transfer of w3 with no tlast -> CNT if match, else DRAIN; tlast on any of w0..w3 -> HDR, ShortCount+1, w=0.
REQ-023 CNT captures w4 and w5 into a candidate register; tlast on w4 -> HDR, ShortCount+1; transfer of w5 with tlast -> COMMIT; transfer of w5 without tlast -> DRAIN with the commit pending.
REQ-024 DRAIN consumes words until tlast; on tlast -> COMMIT if a commit is pending, else HDR with DropCount+1 (mismatched frame).
REQ-025 COMMIT lasts one cycle with RxAxiTready=1 and the transfer counted as w0 of the next frame; if candidate >= AckFrameCount (unsigned), AckFrameCount<=candidate and AckValid=1 in the following cycle; otherwise StaleCount+1 and AckFrameCount is unchanged; next state HDR (w=1 if a word transferred, else 0).
REQ-026 Statistics counters SHALL saturate at all-ones and never wrap.
REQ-027 InFlight = TxFrameCount - AckFrameCount, computed modulo 2^64.
REQ-028 Throttle SHALL be registered: Throttle <= (InFlight > {32'b0,MaxInFlight}), updated every cycle; latency 1 cycle from any input or AckFrameCount change.
REQ-029 Word counter SHALL saturate at MIN_WORDS so that long frames do not wrap it.
REQ-030 Cycles with RxAxiTvalid low SHALL not change the state or w.

Reset
REQ-031 On reset the block SHALL enter RST; w=0; match flag and pending flag cleared; candidate=0.
REQ-032 Reset values: RxAxiTready=0, AckValid=0, AckFrameCount=0, Throttle=0, DropCount=ShortCount=StaleCount=0.
REQ-033 Reset in the middle of a frame SHALL discard the partial frame with no counter update; the next word after RST is treated as w0.

Verification
REQ-034 Matching 6-word frame, Count=0x0000_0001_0000_0005, tlast on w5 -> AckValid pulse 1 cycle after COMMIT, AckFrameCount=0x1_0000_0005.
REQ-035 Frame with DstMac off by 1 bit, 8 words -> no AckValid, DropCount=1, AckFrameCount unchanged.
REQ-036 4-word frame with tlast on w3 -> ShortCount=1, next frame parsed correctly from w0.
REQ-037 Accept Count=10, then Count=7 -> StaleCount=1, AckFrameCount stays 10.
REQ-038 TxFrameCount=300, AckFrameCount=100, MaxInFlight=150 -> Throttle=1; ack with Count=160 -> Throttle=0 one cycle after the AckFrameCount update.
REQ-039 Reset asserted after w2 of a matching frame, then a full matching frame with Count=3 -> AckFrameCount=3, all counters 0.

Source files
------------

// File: rtl/rvvi_ack_depacketizer.sv
// Receive-side parser for acknowledgement frames. Checks the Ethernet-style
// header against the local MAC and expected type fields, extracts the 64-bit
// acknowledged frame count, keeps the largest count seen, and derives a
// throttle signal from the number of frames still in flight.
module rvvi_ack_depacketizer #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MIN_WORDS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          RxAxiTdata,
  input  logic                 RxAxiTvalid,
  input  logic                 RxAxiTlast,
  output logic                 RxAxiTready,
  input  logic [47:0]          LocalMac,
  input  logic [15:0]          EthType,
  input  logic [15:0]          AckType,
  input  logic [63:0]          TxFrameCount,
  input  logic [31:0]          MaxInFlight,
  output logic                 AckValid,
  output logic [63:0]          AckFrameCount,
  output logic                 Throttle,
  output logic [CNT_WIDTH-1:0] DropCount,
  output logic [CNT_WIDTH-1:0] ShortCount,
  output logic [CNT_WIDTH-1:0] StaleCount
);

  localparam int unsigned WW = $clog2(MIN_WORDS + 1);
  localparam logic [WW-1:0] W3   = WW'(3);
  localparam logic [WW-1:0] W4   = WW'(4);
  localparam logic [WW-1:0] W5   = WW'(5);
  localparam logic [WW-1:0] WMAX = WW'(MIN_WORDS);

  typedef enum logic [2:0] {RST, HDR, CNT, DRAIN, COMMIT} state_t;

  state_t          state;
  state_t          stateNext;
  logic [WW-1:0]   wordIdx;
  logic [WW-1:0]   hdrIdx;
  logic            matchFlag;
  logic            matchNext;
  logic            pending;
  logic [63:0]     candidate;
  logic [63:0]     inFlight;
  logic            xfer;
  logic            shortEvt;
  logic            dropEvt;
  logic            commitAccept;
  logic            staleEvt;

  assign xfer     = RxAxiTvalid & RxAxiTready;
  assign inFlight = TxFrameCount - AckFrameCount;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RST;
    else       state <= stateNext;
  end

  // Next-state decode from the word index and tlast of each transfer.
  always_comb begin
    stateNext = state;
    unique case (state)
      RST:    stateNext = HDR;
      HDR: begin
        if (xfer && !RxAxiTlast && wordIdx == W3)
          stateNext = matchNext ? CNT : DRAIN;
      end
      CNT: begin
        if (xfer) begin
          if (RxAxiTlast)         stateNext = (wordIdx == W5) ? COMMIT : HDR;
          else if (wordIdx == W5) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && RxAxiTlast) stateNext = pending ? COMMIT : HDR;
      end
      COMMIT: stateNext = HDR;
      default: stateNext = RST;
    endcase
  end

  // Outputs decoded from state alone.
  always_comb begin
    RxAxiTready = (state != RST);
  end

  // Header match accumulation and per-frame event decode. A word accepted in
  // COMMIT is the first word of the following frame, so it is matched as w0.
  always_comb begin
    hdrIdx = (state == COMMIT) ? '0 : wordIdx;
    unique case (hdrIdx)
      WW'(0):  matchNext = (RxAxiTdata == LocalMac[31:0]);
      WW'(1):  matchNext = matchFlag & (RxAxiTdata[15:0] == LocalMac[47:32]);
      W3:      matchNext = matchFlag & (RxAxiTdata == {AckType, EthType});
      default: matchNext = matchFlag;
    endcase
    shortEvt     = xfer & RxAxiTlast &
                   ((state == HDR) | (state == COMMIT) | ((state == CNT) & (wordIdx == W4)));
    dropEvt      = (state == DRAIN) & xfer & RxAxiTlast & ~pending;
    commitAccept = (state == COMMIT) & (candidate >= AckFrameCount);
    staleEvt     = (state == COMMIT) & ~commitAccept;
  end

  // Datapath: word counter, candidate capture, ack commit, statistics, throttle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wordIdx       <= '0;
      matchFlag     <= 1'b0;
      pending       <= 1'b0;
      candidate     <= '0;
      AckFrameCount <= '0;
      AckValid      <= 1'b0;
      Throttle      <= 1'b0;
      DropCount     <= '0;
      ShortCount    <= '0;
      StaleCount    <= '0;
    end else begin
      AckValid <= 1'b0;
      Throttle <= (inFlight > {32'b0, MaxInFlight});

      if (state == RST)
        wordIdx <= '0;
      else if (state == COMMIT)
        wordIdx <= (xfer && !RxAxiTlast) ? WW'(1) : '0;
      else if (xfer)
        wordIdx <= RxAxiTlast ? '0 : ((wordIdx == WMAX) ? WMAX : wordIdx + WW'(1));

      if (xfer && (state == HDR || state == COMMIT))
        matchFlag <= matchNext;

      if (state == CNT && xfer) begin
        if (wordIdx == W4) candidate[31:0]  <= RxAxiTdata;
        if (wordIdx == W5) candidate[63:32] <= RxAxiTdata;
        if (wordIdx == W5 && !RxAxiTlast) pending <= 1'b1;
      end

      if (state == COMMIT) begin
        pending <= 1'b0;
        if (commitAccept) begin
          AckFrameCount <= candidate;
          AckValid      <= 1'b1;
        end
      end

      if (shortEvt && ShortCount != '1) ShortCount <= ShortCount + 1'b1;
      if (dropEvt  && DropCount  != '1) DropCount  <= DropCount  + 1'b1;
      if (staleEvt && StaleCount != '1) StaleCount <= StaleCount + 1'b1;
    end
  end

endmodule
